// File: rtl/horner_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : horner_seq_if
// Brief   : Coefficient-write, start and result signals of the Horner evaluator.
// Rev     : 1.0
// ============================================================================
interface horner_seq_if #(
    parameter int ADDR_W = 3
);
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [31:0]       coef_data;
    logic              start;
    logic [ADDR_W-1:0] deg;
    logic [31:0]       x;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       result;

    modport master (
        output coef_we, coef_addr, coef_data, start, deg, x,
        input  busy, done, err, result
    );

    modport slave (
        input  coef_we, coef_addr, coef_data, start, deg, x,
        output busy, done, err, result
    );
endinterface
`default_nettype wire

// File: rtl/horner_seq.sv
`default_nettype none
// ============================================================================
// Module  : horner_seq
// Brief   : Sequential Horner evaluator, one shared 32-bit multiply-add per clock.
// Rev     : 1.0
// ============================================================================
module horner_seq #(
    parameter int N_COEF = 6,
    parameter int ADDR_W = 3
) (
    input  wire logic   clk,
    input  wire logic   rst,
    horner_seq_if.slave bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [ADDR_W-1:0] c_max_deg = ADDR_W'(N_COEF - 1);
    localparam logic [ADDR_W:0]   c_n_coef  = (ADDR_W + 1)'(N_COEF);
    localparam logic [ADDR_W-1:0] c_one     = ADDR_W'(1);

    state_t            r_state;
    logic [31:0]       r_coef [N_COEF];
    logic [31:0]       r_acc;
    logic [31:0]       r_x;
    logic [31:0]       r_result;
    logic [ADDR_W-1:0] r_idx;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    state_t            w_state_nxt;
    logic [31:0]       w_acc_nxt;
    logic [31:0]       w_x_nxt;
    logic [31:0]       w_result_nxt;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_coef_we;

    logic [ADDR_W-1:0] w_rd_idx;
    logic [31:0]       w_coef_rd;
    logic [31:0]       w_coef_deg;
    logic [31:0]       w_fma;

    // Shared FMA_32 datapath: (acc * x_r)[31:0] + coef[idx-1], carry dropped.
    assign w_rd_idx   = r_idx - c_one;
    assign w_coef_rd  = r_coef[w_rd_idx];
    assign w_coef_deg = r_coef[bus.deg];
    assign w_fma      = (r_acc * r_x) + w_coef_rd;

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_x_nxt      = r_x;
        w_idx_nxt    = r_idx;
        w_result_nxt = r_result;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_coef_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Any start attempt, accepted or rejected, blocks a same-cycle write.
                if (bus.start) begin
                    if (bus.deg <= c_max_deg) begin
                        w_x_nxt   = bus.x;
                        w_acc_nxt = w_coef_deg;
                        w_idx_nxt = bus.deg;
                        if (bus.deg == '0) begin
                            w_result_nxt = w_coef_deg;
                            w_done_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = ST_RUN;
                            w_busy_nxt  = 1'b1;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (bus.coef_we && ({1'b0, bus.coef_addr} < c_n_coef)) begin
                    w_coef_we = 1'b1;
                end
            end
            ST_RUN: begin
                w_acc_nxt = w_fma;
                w_idx_nxt = w_rd_idx;
                if (r_idx == c_one) begin
                    w_result_nxt = w_fma;
                    w_done_nxt   = 1'b1;
                    w_busy_nxt   = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_x      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                r_coef[i] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_x      <= w_x_nxt;
            r_result <= w_result_nxt;
            r_idx    <= w_idx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
            if (w_coef_we) begin
                r_coef[bus.coef_addr] <= bus.coef_data;
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.result = r_result;
endmodule
`default_nettype wire

// File: tb/tb_horner_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_horner_seq
// Brief   : Directed self-checking bench for horner_seq (N_COEF=6, ADDR_W=3).
// Rev     : 1.0
// ============================================================================
module tb_horner_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    horner_seq_if #(.ADDR_W(3)) bus ();

    horner_seq #(.N_COEF(6), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All stimulus changes happen 1ns after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [31:0] d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = a;
        bus.coef_data = d;
        tick();
        bus.coef_we   = 1'b0;
    endtask

    // Returns edges from accept to done (0 => done right after accept) and busy samples.
    task automatic run_eval(input logic [2:0] d, input logic [31:0] xv,
                            output int lat, output int bcnt);
        bus.start = 1'b1;
        bus.deg   = d;
        bus.x     = xv;
        tick();
        bus.start = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!bus.done && lat < 50) begin
            if (bus.busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        bus.start = 1'b0; bus.deg = '0; bus.x = '0;
        tick(); tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b result=%h, expected 0/0/0/0",
                     bus.busy, bus.done, bus.err, bus.result);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_deg2();
        int lat, bcnt;
        write_coef(3'd0, 32'd3);
        write_coef(3'd1, 32'd2);
        write_coef(3'd2, 32'd1);
        run_eval(3'd2, 32'd5, lat, bcnt);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL deg2_latency: got %0d expected 2", lat); end
        n_checks++;
        if (bus.result !== 32'd38) begin n_fail++; $display("FAIL deg2_result: got %0d expected 38", bus.result); end
        n_checks++;
        if (bcnt !== 2) begin n_fail++; $display("FAIL deg2_busy_cycles: got %0d expected 2", bcnt); end
        tick();
        n_checks++;
        if (bus.done !== 1'b0 || bus.result !== 32'd38) begin
            n_fail++;
            $display("FAIL deg2_done_pulse: got done=%b result=%0d expected done=0 result=38", bus.done, bus.result);
        end
    endtask

    task automatic test_illegal();
        int lat, bcnt;
        bus.start = 1'b1; bus.deg = 3'd6; bus.x = 32'd9;
        bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 32'd77;
        tick();
        bus.start = 1'b0; bus.coef_we = 1'b0;
        n_checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd38) begin
            n_fail++;
            $display("FAIL illegal_deg_err: got err=%b busy=%b done=%b result=%0d expected 1/0/0/38",
                     bus.err, bus.busy, bus.done, bus.result);
        end
        tick();
        n_checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_err_pulse: got err=%b busy=%b expected 0/0", bus.err, bus.busy);
        end
        write_coef(3'd6, 32'hDEAD_0006);
        write_coef(3'd7, 32'hDEAD_0007);
        run_eval(3'd2, 32'd5, lat, bcnt);
        n_checks++;
        if (bus.result !== 32'd38 || lat !== 2) begin
            n_fail++;
            $display("FAIL illegal_no_write: got result=%0d lat=%0d expected 38/2", bus.result, lat);
        end
    endtask

    task automatic test_deg0();
        int lat, bcnt;
        write_coef(3'd0, 32'h1234_5678);
        run_eval(3'd0, 32'hFFFF_FFFF, lat, bcnt);
        n_checks++;
        if (lat !== 0 || bcnt !== 0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL deg0_timing: got lat=%0d busy_cycles=%0d busy=%b expected 0/0/0", lat, bcnt, bus.busy);
        end
        n_checks++;
        if (bus.result !== 32'h1234_5678) begin
            n_fail++; $display("FAIL deg0_result: got %h expected 12345678", bus.result);
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL deg0_after: got done=%b busy=%b expected 0/0", bus.done, bus.busy);
        end
    endtask

    task automatic test_wrap();
        int lat, bcnt;
        write_coef(3'd1, 32'hFFFF_FFFF);
        write_coef(3'd0, 32'd2);
        run_eval(3'd1, 32'd2, lat, bcnt);
        n_checks++;
        if (bus.result !== 32'h0000_0000 || lat !== 1) begin
            n_fail++;
            $display("FAIL wrap_result: got result=%h lat=%0d expected 00000000/1", bus.result, lat);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 6; i++) write_coef(3'(i), 32'(i + 1));
    endtask

    task automatic test_busy_interlock();
        int lat, bcnt;
        bit err_seen;
        load_ramp();
        bus.start = 1'b1; bus.deg = 3'd5; bus.x = 32'd2;
        tick();
        bus.start = 1'b0;
        lat = 0; bcnt = 0; err_seen = 1'b0;
        while (!bus.done && lat < 50) begin
            if (bus.busy) bcnt++;
            if (bus.err) err_seen = 1'b1;
            if (lat == 1) begin
                bus.start = 1'b1; bus.deg = 3'd1; bus.x = 32'd3;
                bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 32'd99;
            end else begin
                bus.start = 1'b0; bus.coef_we = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0; bus.coef_we = 1'b0;
        n_checks++;
        if (bus.result !== 32'd321 || lat !== 5) begin
            n_fail++;
            $display("FAIL interlock_result: got result=%0d lat=%0d expected 321/5", bus.result, lat);
        end
        n_checks++;
        if (bcnt !== 5 || err_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL interlock_busy: got busy_cycles=%0d err_seen=%b expected 5/0", bcnt, err_seen);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL interlock_not_queued: got busy=%b done=%b expected 0/0", bus.busy, bus.done);
        end
        run_eval(3'd0, 32'd7, lat, bcnt);
        n_checks++;
        if (bus.result !== 32'd1) begin
            n_fail++; $display("FAIL interlock_coef0: got %0d expected 1", bus.result);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        run_eval(3'd1, 32'd2, lat, bcnt);
        n_checks++;
        if (bus.result !== 32'd5 || lat !== 1) begin
            n_fail++; $display("FAIL b2b_first: got result=%0d lat=%0d expected 5/1", bus.result, lat);
        end
        // Next start issued in the cycle done is high.
        run_eval(3'd2, 32'd3, lat, bcnt);
        n_checks++;
        if (bus.result !== 32'd34 || lat !== 2) begin
            n_fail++; $display("FAIL b2b_second: got result=%0d lat=%0d expected 34/2", bus.result, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        bit bad;
        bus.start = 1'b1; bus.deg = 3'd5; bus.x = 32'd2;
        tick();
        bus.start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.result !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got busy=%b done=%b err=%b result=%0d expected 0/0/0/0",
                     bus.busy, bus.done, bus.err, bus.result);
        end
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL midreset_no_done: got activity after abort, expected none"); end
        run_eval(3'd0, 32'd5, lat, bcnt);
        n_checks++;
        if (bus.result !== 32'd0 || lat !== 0) begin
            n_fail++; $display("FAIL midreset_cleared: got result=%0d lat=%0d expected 0/0", bus.result, lat);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_deg2();
        test_illegal();
        test_deg0();
        test_wrap();
        test_busy_interlock();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/horner_seq.md
# horner_seq

Sequential Horner polynomial evaluator that time-shares a single `FMA_32` instance. It computes p(x) = c[N]·x^N + … + c[1]·x + c[0] one fused multiply-add per clock. Coefficients come from an internal register file. It replaces the fully unrolled three-stage FMA chain with a single FMA, trading latency for area, and is the controller that sequences that shared multiply-add datapath.

## Interface
Parameters:
- `N_COEF`, default 6: number of coefficient registers; maximum degree is N_COEF-1.
- `ADDR_W`, default 3: width of `coef_addr` and `deg`. Requires N_COEF ≤ 2^ADDR_W.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `coef_we` input 1: coefficient write strobe.
- `coef_addr` input ADDR_W: coefficient index to write.
- `coef_data` input 32: coefficient value.
- `start` input 1: request an evaluation.
- `deg` input ADDR_W: polynomial degree for this evaluation.
- `x` input 32: evaluation point.
- `busy` output 1: evaluation in progress.
- `done` output 1: one-cycle pulse; `result` is valid from this cycle onward.
- `err` output 1: one-cycle pulse; `start` was rejected because `deg` is out of range.
- `result` output 32: last completed p(x).

## Operation
- Arithmetic:
  - Unsigned, modulo 2^32, with exactly `FMA_32` semantics: out = (a·b)[31:0] + c, carry discarded.
  - One `FMA_32` instance with a = acc, b = x_r, c = coef[idx-1].
- Registers:
  - coef[0..N_COEF-1], 32 bits each.
  - acc, 32 bits.
  - x_r, 32 bits.
  - idx, ADDR_W bits.
  - result, 32 bits.
  - state.
- FSM states: IDLE, RUN.
- IDLE:
  - `start`=1 and `deg` ≤ N_COEF-1: capture x_r←x, acc←coef[deg], idx←deg.
    - If deg=0, go to the completion action below.
    - Otherwise go to RUN, busy←1.
  - `start`=1 and `deg` > N_COEF-1: err←1 for one cycle. State, busy and result are unchanged.
- RUN, each cycle:
  - acc←FMA(acc, x_r, coef[idx-1]), idx←idx-1.
  - When idx=1 (last step), take the completion action.
- Completion action:
  - result←final acc value (FMA output, or coef[0] when deg=0).
  - done←1 for one cycle, busy←0, state←IDLE.
- Coefficient writes:
  - Performed only in IDLE, and only when no start is accepted in the same cycle.
  - Ignored when busy=1, when a start is accepted in the same cycle, or when coef_addr ≥ N_COEF.
- `start` while busy=1 is ignored. It is not queued and produces no err.
- `x` and `deg` are sampled only at the accepting edge; later changes have no effect on the evaluation in progress.
- `result` holds its value between completions and is unaffected by rejected starts.
- The err-reject cycle is treated as a start attempt, so a coefficient write in that same cycle is also ignored.

## Timing
- Reset values: busy=0, done=0, err=0, result=0, acc=0, x_r=0, idx=0, all coef=0, state=IDLE.
- Reset mid-evaluation aborts immediately. No done pulse; all of the reset values above apply.
- Latency: with start accepted at edge k, done is high during the cycle after edge k+deg. result is valid from that same cycle.
  - deg=0: 1 cycle.
  - deg=N_COEF-1: N_COEF cycles.
- busy is high from after edge k until after edge k+deg; it is never high for deg=0.
- A new start may be accepted in the same cycle done is high (state is IDLE), giving back-to-back throughput of deg+1 cycles per evaluation.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Degree 2:
  - Write coef[0]=3, coef[1]=2, coef[2]=1, then start with x=5, deg=2.
  - Required: done 2 cycles after the accepting edge, result=38, busy high for exactly 2 cycles.
- Degree 0:
  - Start with deg=0, coef[0]=0x12345678, x=0xFFFFFFFF.
  - Required: done after 1 cycle, result=0x12345678, busy never asserted.
- Wrap-around:
  - Set coef[1]=0xFFFFFFFF, coef[0]=2, then start with x=2, deg=1.
  - Required: result=0x00000000 (modulo 2^32).
- Illegal degree and illegal address:
  - Start with deg=6 (N_COEF=6). Required: err pulses for 1 cycle, busy=0, result keeps its previous value.
  - Write with coef_addr=7. Required: no coefficient changes.
- Busy interlock:
  - During a deg=5 run, pulse start and write coef[0]=99.
  - Required: the second start is ignored, coef[0] is unchanged, and result equals the value computed with the original coefficients.
- Reset mid-run:
  - Assert rst 2 cycles into a deg=5 run.
  - Required: outputs go to reset values immediately, no done pulse.
  - A following deg=0 start returns result=0 because coefficients were cleared.
